// File: rtl/uart_cmd_rx_if.sv
// Command/response handshake between the UART front end (master) and the
// command-processing stage (slave).
interface uart_cmd_rx_if;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;

  modport master (
    output cmd, data, cmd_rdy, resp_sent,
    input  clr_cmd_rdy, resp, send_resp
  );

  modport slave (
    input  cmd, data, cmd_rdy, resp_sent,
    output clr_cmd_rdy, resp, send_resp
  );
endinterface

// File: rtl/uart_cmd_rx.sv
// 8N1 UART command front end: receives 3-byte command frames (cmd, data hi,
// data lo) and transmits single response bytes, full duplex.
module uart_cmd_rx #(
  parameter int BAUD_DIV = 2604,
  parameter int FRAME_TO = 80000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RX,
  output logic             TX,
  uart_cmd_rx_if.master    host
);

  localparam int              TW     = $clog2(FRAME_TO + 1);
  localparam logic [11:0]     BAUD_L = 12'(BAUD_DIV);
  localparam logic [11:0]     BAUD_M = 12'(BAUD_DIV - 1);
  localparam logic [11:0]     HALF_L = 12'(BAUD_DIV / 2);
  localparam logic [TW-1:0]   TO_L   = TW'(FRAME_TO - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {F_CMD, F_HI, F_LO} f_state_e;
  typedef enum logic       {TX_IDLE, TX_SHIFT} tx_state_e;

  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e   rx_state_q;
  logic [11:0] rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_shift_q;

  f_state_e    f_state_q;
  logic [7:0]  pcmd_q, hi_q, cmd_q;
  logic [15:0] data_q;
  logic        cmd_rdy_q;
  logic [TW-1:0] tmr_q;

  tx_state_e   tx_state_q;
  logic [9:0]  tx_sh_q;
  logic [11:0] tx_cnt_q;
  logic [3:0]  tx_bit_q;
  logic        tx_q, resp_sent_q;

  logic start_det_d, smp_d, byte_vld_d, frame_err_d, tx_load_d;

  // Previous-sample flop turns the synchronized level into a falling-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= RX;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign start_det_d = (rx_state_q == RX_IDLE) && rx_prev_q && !rx_s2_q;
  assign smp_d       = (rx_cnt_q == 12'd1);
  assign byte_vld_d  = (rx_state_q == RX_STOP) && smp_d && rx_s2_q;
  assign frame_err_d = (rx_state_q == RX_STOP) && smp_d && !rx_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= 12'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (start_det_d) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= HALF_L;
          end
        end
        RX_START: begin
          if (smp_d) begin
            if (rx_s2_q) begin
              rx_state_q <= RX_IDLE;
              rx_cnt_q   <= 12'd0;
            end else begin
              rx_state_q <= RX_DATA;
              rx_cnt_q   <= BAUD_L;
              rx_bit_q   <= 3'd0;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - 12'd1;
          end
        end
        RX_DATA: begin
          if (smp_d) begin
            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            rx_cnt_q   <= BAUD_L;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q - 12'd1;
          end
        end
        RX_STOP: begin
          if (smp_d) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= 12'd0;
          end else begin
            rx_cnt_q <= rx_cnt_q - 12'd1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Frame assembly; a completing frame's set of cmd_rdy overrides a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_state_q <= F_CMD;
      pcmd_q    <= 8'd0;
      hi_q      <= 8'd0;
      cmd_q     <= 8'd0;
      data_q    <= 16'd0;
      cmd_rdy_q <= 1'b0;
      tmr_q     <= '0;
    end else begin
      if (host.clr_cmd_rdy) cmd_rdy_q <= 1'b0;

      if (frame_err_d) begin
        f_state_q <= F_CMD;
      end else if (byte_vld_d) begin
        case (f_state_q)
          F_CMD: begin
            pcmd_q    <= rx_shift_q;
            f_state_q <= F_HI;
          end
          F_HI: begin
            hi_q      <= rx_shift_q;
            f_state_q <= F_LO;
          end
          F_LO: begin
            cmd_q     <= pcmd_q;
            data_q    <= {hi_q, rx_shift_q};
            cmd_rdy_q <= 1'b1;
            f_state_q <= F_CMD;
          end
          default: f_state_q <= F_CMD;
        endcase
      end else if (f_state_q != F_CMD && rx_state_q == RX_IDLE &&
                   !start_det_d && tmr_q == TO_L) begin
        f_state_q <= F_CMD;
      end

      // Inter-byte timer only counts while a partial frame waits on an idle line
      if (f_state_q == F_CMD || start_det_d || rx_state_q != RX_IDLE || tmr_q == TO_L)
        tmr_q <= '0;
      else
        tmr_q <= tmr_q + 1'b1;
    end
  end

  // A response can be loaded from idle or on the final clock of the previous stop bit
  assign tx_load_d = host.send_resp &&
                     (tx_state_q == TX_IDLE || (tx_cnt_q == 12'd0 && tx_bit_q == 4'd9));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q  <= TX_IDLE;
      tx_sh_q     <= 10'h3FF;
      tx_cnt_q    <= 12'd0;
      tx_bit_q    <= 4'd0;
      tx_q        <= 1'b1;
      resp_sent_q <= 1'b0;
    end else begin
      resp_sent_q <= (tx_state_q == TX_SHIFT) && (tx_bit_q == 4'd9) && (tx_cnt_q == 12'd1);
      if (tx_load_d) begin
        tx_state_q <= TX_SHIFT;
        tx_sh_q    <= {1'b1, host.resp, 1'b0};
        tx_q       <= 1'b0;
        tx_cnt_q   <= BAUD_M;
        tx_bit_q   <= 4'd0;
      end else if (tx_state_q == TX_SHIFT) begin
        if (tx_cnt_q == 12'd0) begin
          if (tx_bit_q == 4'd9) begin
            tx_state_q <= TX_IDLE;
            tx_q       <= 1'b1;
          end else begin
            tx_q     <= tx_sh_q[1];
            tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
            tx_bit_q <= tx_bit_q + 4'd1;
            tx_cnt_q <= BAUD_M;
          end
        end else begin
          tx_cnt_q <= tx_cnt_q - 12'd1;
        end
      end
    end
  end

  assign TX             = tx_q;
  assign host.cmd       = cmd_q;
  assign host.data      = data_q;
  assign host.cmd_rdy   = cmd_rdy_q;
  assign host.resp_sent = resp_sent_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: byte-level host model drives RX, a frame/response
// model predicts cmd/data/cmd_rdy/TX/resp_sent and is compared every clock.
module tb_uart_cmd_rx;

  localparam int B  = 16;
  localparam int TO = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic RX = 1'b1;
  logic TX;

  uart_cmd_rx_if bus();

  uart_cmd_rx #(.BAUD_DIV(B), .FRAME_TO(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RX    (RX),
    .TX    (TX),
    .host  (bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Expected frame state: bytes of the frame collected so far, plus outputs
  logic [7:0]  m_part[$];
  logic [7:0]  m_cmd  = 8'h00;
  logic [15:0] m_data = 16'h0000;
  logic        m_rdy  = 1'b0;
  logic        rx_busy = 1'b0;
  int          last_end = 0;

  // Expected transmitter: start cycle and byte of the response on the wire
  logic        tx_act  = 1'b0;
  int          tx_t0   = 0;
  logic [7:0]  tx_byte = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_act <= 1'b0;
    else if (bus.send_resp && (!tx_act || (cyc + 1 - tx_t0) >= 10 * B)) begin
      tx_act  <= 1'b1;
      tx_t0   <= cyc + 1;
      tx_byte <= bus.resp;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_busy = 1'b1;
    if (m_part.size() != 0 && (cyc - last_end) > TO) m_part.delete();
    @(negedge clk) RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (B) @(negedge clk);
    end
    RX = stop;
    repeat (B) @(negedge clk);
    RX = 1'b1;
    if (!stop) m_part.delete();
    else begin
      m_part.push_back(b);
      if (m_part.size() == 3) begin
        m_cmd  = m_part[0];
        m_data = {m_part[1], m_part[2]};
        m_rdy  = 1'b1;
        m_part.delete();
      end
    end
    last_end = cyc;
    rx_busy  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l);
    send_byte(c, 1'b1);
    send_byte(h, 1'b1);
    send_byte(l, 1'b1);
  endtask

  task automatic pulse_clr();
    @(negedge clk) bus.clr_cmd_rdy = 1'b1;
    @(posedge clk) m_rdy = 1'b0;
    @(negedge clk) bus.clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    logic [9:0] wav;
    bus.clr_cmd_rdy = 1'b0;
    bus.resp        = 8'h00;
    bus.send_resp   = 1'b0;
    wav             = 10'b11_0100_1010;

    repeat (3) @(negedge clk);
    chk("reset_TX", 32'(TX), 32'h1);
    chk("reset_cmd", 32'(bus.cmd), 32'h00);
    chk("reset_data", 32'(bus.data), 32'h0000);
    chk("reset_cmd_rdy", 32'(bus.cmd_rdy), 32'h0);
    chk("reset_resp_sent", 32'(bus.resp_sent), 32'h0);
    rst_n = 1'b1;

    fork
      begin : cmp
        int k;
        logic [9:0] fr;
        logic etx, ers;
        forever begin
          @(negedge clk);
          if (rst_n) begin
            k = cyc - tx_t0;
            if (tx_act && k < 10 * B) begin
              fr  = {1'b1, tx_byte, 1'b0};
              etx = fr[k / B];
              ers = (k == 10 * B - 1);
            end else begin
              etx = 1'b1;
              ers = 1'b0;
            end
            chk("TX", 32'(TX), 32'(etx));
            chk("resp_sent", 32'(bus.resp_sent), 32'(ers));
            if (!rx_busy) begin
              chk("cmd", 32'(bus.cmd), 32'(m_cmd));
              chk("data", 32'(bus.data), 32'(m_data));
              chk("cmd_rdy", 32'(bus.cmd_rdy), 32'(m_rdy));
            end
          end
        end
      end
    join_none

    repeat (5) @(negedge clk);

    // Basic frame and clear
    send_frame(8'h05, 8'h00, 8'hA0);
    chk("f1_cmd", 32'(bus.cmd), 32'h05);
    chk("f1_data", 32'(bus.data), 32'h00A0);
    chk("f1_rdy", 32'(bus.cmd_rdy), 32'h1);
    pulse_clr();
    chk("clr_rdy", 32'(bus.cmd_rdy), 32'h0);

    // Response 0xA5, back-to-back 0x3C, ignored mid-byte request
    bus.resp = 8'hA5;
    bus.send_resp = 1'b1;
    @(negedge clk) bus.send_resp = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("tx_wave_A5", 32'(TX), 32'(wav[i]));
      if (i < 9) repeat (16) @(negedge clk);
    end
    repeat (7) @(negedge clk);
    chk("resp_sent_at_159", 32'(bus.resp_sent), 32'h1);
    bus.resp = 8'h3C;
    bus.send_resp = 1'b1;
    @(negedge clk) bus.send_resp = 1'b0;
    chk("b2b_start_bit", 32'(TX), 32'h0);
    repeat (49) @(negedge clk);
    bus.resp = 8'hFF;
    bus.send_resp = 1'b1;
    @(negedge clk) bus.send_resp = 1'b0;
    bus.resp = 8'h00;
    repeat (120) @(negedge clk);
    chk("tx_idle_after", 32'(TX), 32'h1);
    chk("resp_sent_idle", 32'(bus.resp_sent), 32'h0);

    // Framing error drops partial frame
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    send_frame(8'h02, 8'hFF, 8'h01);
    chk("ferr_cmd", 32'(bus.cmd), 32'h02);
    chk("ferr_data", 32'(bus.data), 32'hFF01);

    // Inter-byte timeout
    send_byte(8'h03, 1'b1);
    repeat (300) @(negedge clk);
    send_frame(8'h04, 8'h12, 8'h34);
    send_byte(8'h56, 1'b1);
    chk("to_cmd", 32'(bus.cmd), 32'h04);
    chk("to_data", 32'(bus.data), 32'h1234);
    repeat (300) @(negedge clk);

    // Clear coinciding with frame completion, then overwrite while set
    pulse_clr();
    send_byte(8'h07, 1'b1);
    send_byte(8'hAB, 1'b1);
    fork
      send_byte(8'hCD, 1'b1);
      begin
        @(negedge clk);
        repeat (154) @(posedge clk);
        @(negedge clk) bus.clr_cmd_rdy = 1'b1;
        @(posedge clk) m_rdy = 1'b0;
        @(negedge clk) bus.clr_cmd_rdy = 1'b0;
      end
    join
    chk("coinc_rdy", 32'(bus.cmd_rdy), 32'h1);
    chk("coinc_data", 32'(bus.data), 32'hABCD);
    send_frame(8'h08, 8'h11, 8'h22);
    chk("ovr_cmd", 32'(bus.cmd), 32'h08);
    chk("ovr_data", 32'(bus.data), 32'h1122);
    chk("ovr_rdy", 32'(bus.cmd_rdy), 32'h1);

    // Reset mid-frame and mid-transmit
    send_byte(8'h09, 1'b1);
    bus.resp = 8'h5A;
    bus.send_resp = 1'b1;
    @(negedge clk) bus.send_resp = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre_rst_tx_low", 32'(TX), 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    m_part.delete();
    m_cmd  = 8'h00;
    m_data = 16'h0000;
    m_rdy  = 1'b0;
    #1;
    chk("rst_TX", 32'(TX), 32'h1);
    chk("rst_cmd_rdy", 32'(bus.cmd_rdy), 32'h0);
    chk("rst_cmd", 32'(bus.cmd), 32'h00);
    chk("rst_data", 32'(bus.data), 32'h0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h06, 8'h00, 8'h00);
    chk("post_rst_cmd", 32'(bus.cmd), 32'h06);
    chk("post_rst_data", 32'(bus.data), 32'h0000);
    chk("post_rst_rdy", 32'(bus.cmd_rdy), 32'h1);

    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

Serial command front end of the QuadCopter DUT. Receives the host's 3-byte command frames over an integrated 8N1 UART receiver, assembles them into an 8-bit command plus 16-bit data word for the command/config stage, and transmits that stage's 1-byte response (e.g. POS_ACK 0xA5) back to the host. It sits between the RX/TX pins and the command-processing logic.

## Interface

- BAUD_DIV, 2604, clocks per bit (50 MHz / 19200 baud); legal range 16..4095.
- FRAME_TO, 80000, max idle clocks between end of one byte's stop bit and next start bit inside a frame.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- RX  in  1  serial input from host, idle high, asynchronous to clk.
- TX  out  1  serial output to host, idle high.
- cmd  out  8  command byte of last complete frame.
- data  out  16  data word of last complete frame ({byte2, byte3}).
- cmd_rdy  out  1  level; set when a full frame has been latched.
- clr_cmd_rdy  in  1  one-cycle pulse from consumer; clears cmd_rdy.
- resp  in  8  response byte to transmit.
- send_resp  in  1  one-cycle pulse; starts transmission of resp.
- resp_sent  out  1  one-cycle pulse when stop bit of response completes.

## Operation

- Reset values: TX=1, cmd=0x00, data=0x0000, cmd_rdy=0, resp_sent=0; RX synchronizer flops preset to 1; all FSMs idle, counters 0.
- RX path: RX passes through a 2-flop synchronizer. Receiver FSM RX_IDLE -> RX_START -> RX_DATA -> RX_STOP -> RX_IDLE.
  - RX_IDLE: falling edge of synchronized RX -> RX_START, baud counter loaded with BAUD_DIV/2.
  - RX_START: at count expiry, resample; if 1 (glitch) -> RX_IDLE, else -> RX_DATA, counter = BAUD_DIV.
  - RX_DATA: 8 samples at BAUD_DIV intervals, LSB first, shifted into a byte register.
  - RX_STOP: sample at BAUD_DIV; 1 -> byte valid (one-cycle internal strobe); 0 -> framing error, byte discarded.
- Frame assembler FSM F_CMD -> F_HI -> F_LO -> F_CMD.
  - Valid byte in F_CMD: held as pending cmd; F_HI: held as high data; F_LO: cmd/data outputs updated together, cmd_rdy set.
  - Framing error in any state: assembler returns to F_CMD, partial frame dropped, outputs untouched.
  - Inter-byte timer runs in F_HI/F_LO while receiver is RX_IDLE; reaching FRAME_TO -> F_CMD, partial frame dropped. Timer cleared on each start-bit detection.
- cmd_rdy: cleared by clr_cmd_rdy; if frame completion and clr_cmd_rdy coincide, set wins. A new frame completing while cmd_rdy=1 overwrites cmd/data, cmd_rdy stays 1 (no overrun flag).
- TX path: FSM TX_IDLE -> TX_SHIFT -> TX_IDLE. send_resp in TX_IDLE loads {1, resp, 0} into a 10-bit shift register; bits driven LSB first, BAUD_DIV clocks each. send_resp while in TX_SHIFT is ignored (resp not re-sampled). RX and TX are fully independent (full duplex).
- Reset mid-operation: asynchronous return to reset values; a partially received frame is dropped, a partially sent byte is truncated with TX forced high.

## Timing

- RX byte sampled mid-bit: start bit at BAUD_DIV/2, data bit n at BAUD_DIV/2 + (n+1)·BAUD_DIV after the synchronized falling edge; stop at +9·BAUD_DIV.
- cmd_rdy and new cmd/data visible the clock after the third byte's stop-bit sample (synchronizer adds 2 clocks from pin edge).
- TX goes low the clock after send_resp; each bit exactly BAUD_DIV clocks; full byte 10·BAUD_DIV clocks.
- resp_sent pulses in the last clock of the stop bit; a send_resp in the following cycle is accepted (back-to-back bytes, no idle gap).
- Timeout fires exactly FRAME_TO clocks after the receiver re-enters RX_IDLE.

## Test plan

- BAUD_DIV=16: host sends 0x05,0x00,0xA0 -> cmd=0x05, data=0x00A0, cmd_rdy=1; clr_cmd_rdy pulse -> cmd_rdy=0 next clock.
- send_resp with resp=0xA5 -> TX waveform 0,1,0,1,0,0,1,0,1,1 at 16-clock bits, resp_sent pulse after 160 clocks, TX high after.
- Second byte sent with stop bit 0 then full frame 0x02,0xFF,0x01 -> first partial dropped; cmd=0x02, data=0xFF01.
- FRAME_TO=200: send 0x03, idle 300 clocks, then 0x04,0x12,0x34,0x56 -> cmd=0x04, data=0x1234; byte 0x56 left pending in F_HI.
- clr_cmd_rdy asserted in the same cycle a frame completes -> cmd_rdy=1; second frame while cmd_rdy=1 -> outputs overwritten, cmd_rdy stays 1.
- rst_n low mid-frame and mid-TX -> TX=1, cmd_rdy=0, cmd/data=0 immediately; next clean frame 0x06,0x00,0x00 -> cmd=0x06, cmd_rdy=1.
